// File: rtl/wb_arbiter_n_if.sv
// Bus bundle for the N-master Wishbone arbiter: flat-packed master-side
// vectors (master k in slice k), the single slave port and status outputs.
interface wb_arbiter_n_if #(
  parameter int NUM_M = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int SW = DW / 8;

  logic [NUM_M-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NUM_M*AW-1:0]   m_adr_i;
  logic [NUM_M*DW-1:0]   m_dat_i;
  logic [NUM_M*SW-1:0]   m_sel_i;
  logic [NUM_M*3-1:0]    m_cti_i;
  logic [NUM_M*2-1:0]    m_bte_i;
  logic [DW-1:0]         m_dat_o;
  logic [NUM_M-1:0]      m_ack_o, m_err_o, m_rty_o;

  logic                  s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]         s_adr_o;
  logic [DW-1:0]         s_dat_o;
  logic [SW-1:0]         s_sel_o;
  logic [2:0]            s_cti_o;
  logic [1:0]            s_bte_o;
  logic                  s_ack_i, s_err_i, s_rty_i;
  logic [DW-1:0]         s_dat_i;

  logic [NUM_M-1:0]      gnt_o;
  logic                  timeout_o;

  // Arbiter side: consumes master requests and slave terminations.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    output gnt_o, timeout_o
  );

  // Environment side: BIU masters plus the external slave.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    input  gnt_o, timeout_o
  );
endinterface

// File: rtl/wb_arbiter_n.sv
// Round-robin N-master to one-slave Wishbone B3 arbiter. Grant is held for a
// whole cyc (bursts, RMW stay atomic); a watchdog errors out hung strobes.
module wb_arbiter_n #(
  parameter int NUM_M       = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_n_if.slave bus
);
  localparam int SW = DW / 8;
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;   // doubles as the granted index
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    win;
  logic             found;
  logic             cyc_g, stb_g, term, fire;
  int               gi;

  assign gi        = int'(last_q);
  assign bus.gnt_o = gnt_q;

  // Granted master's cyc/stb, slave termination and watchdog fire condition.
  always_comb begin
    cyc_g = bus.m_cyc_i[last_q];
    stb_g = bus.m_stb_i[last_q];
    term  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    fire  = (TIMEOUT_CYC != 0) && (state_q == BUSY) && cyc_g && stb_g &&
            !term && (cnt_q == TMO);
  end

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= NUM_M; k++) begin
      if (!found && bus.m_cyc_i[(int'(last_q) + k) % NUM_M]) begin
        found = 1'b1;
        win   = IW'((int'(last_q) + k) % NUM_M);
      end
    end
  end

  // State, grant, last-winner and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_M - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: grant on request, hold for the whole cyc, drain after timeout.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BUSY;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          last_d     = win;
        end
      end
      BUSY: begin
        if (!cyc_g) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (fire) begin
          state_d = DRAIN;
        end else if (stb_g && !term && (TIMEOUT_CYC != 0)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (!cyc_g) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs: slave mux and termination routing only while BUSY.
  always_comb begin
    bus.m_dat_o   = bus.s_dat_i;
    bus.m_ack_o   = '0;
    bus.m_err_o   = '0;
    bus.m_rty_o   = '0;
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_adr_o   = '0;
    bus.s_dat_o   = '0;
    bus.s_sel_o   = '0;
    bus.s_cti_o   = '0;
    bus.s_bte_o   = '0;
    bus.timeout_o = 1'b0;
    if (state_q == BUSY) begin
      bus.s_cyc_o   = cyc_g & ~fire;
      bus.s_stb_o   = stb_g & ~fire;
      bus.s_we_o    = bus.m_we_i[last_q];
      bus.s_adr_o   = bus.m_adr_i[gi*AW +: AW];
      bus.s_dat_o   = bus.m_dat_i[gi*DW +: DW];
      bus.s_sel_o   = bus.m_sel_i[gi*SW +: SW];
      bus.s_cti_o   = bus.m_cti_i[gi*3 +: 3];
      bus.s_bte_o   = bus.m_bte_i[gi*2 +: 2];
      bus.m_ack_o   = gnt_q & {NUM_M{bus.s_ack_i}};
      bus.m_err_o   = gnt_q & {NUM_M{bus.s_err_i | fire}};
      bus.m_rty_o   = gnt_q & {NUM_M{bus.s_rty_i}};
      bus.timeout_o = fire;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: a 4-master/TIMEOUT=8 instance (round robin, burst
// hold, watchdog, reset) and a 2-master/TIMEOUT=0 instance (single read, stall).
module tb_wb_arbiter_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_n_if #(.NUM_M(4), .AW(32), .DW(32)) a_if ();
  wb_arbiter_n_if #(.NUM_M(2), .AW(32), .DW(32)) b_if ();

  wb_arbiter_n #(.NUM_M(4), .AW(32), .DW(32), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  wb_arbiter_n #(.NUM_M(2), .AW(32), .DW(32), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [2:0]  cti;
    logic [31:0] rdat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  gnt;
  } vec_t;
  vec_t rr[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic a_set(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    a_if.m_cyc_i[m]         = cyc;
    a_if.m_stb_i[m]         = stb;
    a_if.m_we_i[m]          = we;
    a_if.m_adr_i[m*32 +: 32] = adr;
    a_if.m_dat_i[m*32 +: 32] = dat;
    a_if.m_sel_i[m*4 +: 4]  = 4'hF;
    a_if.m_cti_i[m*3 +: 3]  = cti;
    a_if.m_bte_i[m*2 +: 2]  = 2'b00;
  endtask

  task automatic b_set(input int m, input logic cyc, input logic stb,
                       input logic [31:0] adr);
    b_if.m_cyc_i[m]          = cyc;
    b_if.m_stb_i[m]          = stb;
    b_if.m_adr_i[m*32 +: 32] = adr;
  endtask

  task automatic push(input logic [3:0] g, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic we, input logic [2:0] cti, input logic [31:0] rdat);
    exp_t e;
    e.gnt = g; e.adr = adr; e.wdat = wdat; e.we = we; e.cti = cti; e.rdat = rdat;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard: every acked beat on instance A is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && a_if.s_ack_i && a_if.s_cyc_o && a_if.s_stb_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow got ack with empty queue adr %h", a_if.s_adr_o);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_gnt",  64'(a_if.gnt_o),   64'(mon_e.gnt));
        chk("sb_adr",  64'(a_if.s_adr_o), 64'(mon_e.adr));
        chk("sb_we",   64'(a_if.s_we_o),  64'(mon_e.we));
        chk("sb_wdat", 64'(a_if.s_dat_o), 64'(mon_e.wdat));
        chk("sb_cti",  64'(a_if.s_cti_o), 64'(mon_e.cti));
        chk("sb_ack",  64'(a_if.m_ack_o), 64'(mon_e.gnt));
        chk("sb_rdat", 64'(a_if.m_dat_o), 64'(mon_e.rdat));
      end
    end
  end

  initial begin
    int n, idle, bad;
    a_if.m_cyc_i = '0; a_if.m_stb_i = '0; a_if.m_we_i = '0; a_if.m_adr_i = '0;
    a_if.m_dat_i = '0; a_if.m_sel_i = '0; a_if.m_cti_i = '0; a_if.m_bte_i = '0;
    a_if.s_ack_i = 1'b0; a_if.s_err_i = 1'b0; a_if.s_rty_i = 1'b0; a_if.s_dat_i = '0;
    b_if.m_cyc_i = '0; b_if.m_stb_i = '0; b_if.m_we_i = '0; b_if.m_adr_i = '0;
    b_if.m_dat_i = '0; b_if.m_sel_i = '0; b_if.m_cti_i = '0; b_if.m_bte_i = '0;
    b_if.s_ack_i = 1'b0; b_if.s_err_i = 1'b0; b_if.s_rty_i = 1'b0; b_if.s_dat_i = '0;

    rr[0] = '{m: 0, adr: 32'h0000_1000, dat: 32'hA0A0_0001, we: 1'b1, gnt: 4'b0001};
    rr[1] = '{m: 1, adr: 32'h0000_2004, dat: 32'h0000_0000, we: 1'b0, gnt: 4'b0010};
    rr[2] = '{m: 2, adr: 32'h0000_3008, dat: 32'hC2C2_0003, we: 1'b1, gnt: 4'b0100};
    rr[3] = '{m: 3, adr: 32'h0000_400C, dat: 32'h0000_0000, we: 1'b0, gnt: 4'b1000};
    rr[4] = '{m: 0, adr: 32'h0000_1040, dat: 32'h0000_0000, we: 1'b0, gnt: 4'b0001};

    // Reset state of both instances
    #2;
    chk("rst_a", 64'({a_if.gnt_o, a_if.s_cyc_o, a_if.s_stb_o, a_if.s_adr_o,
                      a_if.m_ack_o, a_if.m_err_o, a_if.timeout_o}), 64'd0);
    chk("rst_b", 64'({b_if.gnt_o, b_if.s_cyc_o, b_if.s_stb_o, b_if.s_adr_o,
                      b_if.m_err_o, b_if.timeout_o}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // B: master 1 single read, ack on slave's 2nd cycle
    b_set(1, 1'b1, 1'b1, 32'h0000_8870);
    @(negedge clk);
    chk("b_pre_gnt", 64'(b_if.gnt_o), 64'b00);
    @(negedge clk);
    chk("b_gnt", 64'({b_if.gnt_o, b_if.s_cyc_o, b_if.s_stb_o, b_if.m_ack_o}), 64'b10_1_1_00);
    chk("b_adr", 64'(b_if.s_adr_o), 64'h8870);
    @(posedge clk); #1;
    b_if.s_ack_i = 1'b1; b_if.s_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("b_ack", 64'(b_if.m_ack_o), 64'b10);
    chk("b_rdat", 64'(b_if.m_dat_o), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    b_if.s_ack_i = 1'b0; b_if.s_dat_i = '0;
    b_set(1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); @(negedge clk);
    chk("b_idle", 64'({b_if.gnt_o, b_if.s_cyc_o}), 64'd0);

    // B: TIMEOUT_CYC=0 never fires during a long stall
    @(posedge clk); #1;
    b_set(0, 1'b1, 1'b1, 32'h0000_0010);
    @(posedge clk);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (b_if.m_err_o != 0 || b_if.timeout_o || b_if.gnt_o != 2'b01 || !b_if.s_cyc_o) bad++;
    end
    chk("b_stall_bad_cycles", 64'(bad), 64'd0);
    @(posedge clk); #1;
    b_set(0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk); #1;

    // A: round robin with all four masters requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_set(rr[i].m, 1'b1, 1'b1, rr[i].we, rr[i].adr, rr[i].dat, 3'b000);
      push(rr[i].gnt, rr[i].adr, rr[i].dat, rr[i].we, 3'b000, ~rr[i].adr);
    end
    for (int i = 0; i < 5; i++) begin
      n = 0; idle = 0;
      do begin
        @(negedge clk);
        n++;
        if (a_if.gnt_o == 0) idle++;
      end while (!(a_if.s_cyc_o && a_if.s_stb_o) && n < 20);
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL rr_wait got no grant want entry %0d", i);
        break;
      end
      chk("rr_gnt", 64'(a_if.gnt_o), 64'(rr[i].gnt));
      if (i > 0) chk("rr_dead_cycles", 64'(idle), 64'd1);
      if (i == 1) begin
        a_set(rr[4].m, 1'b1, 1'b1, rr[4].we, rr[4].adr, rr[4].dat, 3'b000);
        push(rr[4].gnt, rr[4].adr, rr[4].dat, rr[4].we, 3'b000, ~rr[4].adr);
      end
      @(posedge clk); #1;
      a_if.s_ack_i = 1'b1; a_if.s_dat_i = ~rr[i].adr;
      @(posedge clk); #1;
      a_if.s_ack_i = 1'b0; a_if.s_dat_i = '0;
      a_set(rr[i].m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    end
    repeat (3) @(posedge clk); #1;

    // A: 4-beat burst from master 0 while master 1 requests throughout
    do_reset();
    a_set(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
    a_set(1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0055, 3'b000);
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      a_set(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100 + 32'(4*b), 32'h0,
            (b == 3) ? 3'b111 : 3'b010);
      push(4'b0001, 32'h0000_0100 + 32'(4*b), 32'h0, 1'b0,
           (b == 3) ? 3'b111 : 3'b010, 32'hB000_0000 + 32'(b));
      a_if.s_ack_i = 1'b1; a_if.s_dat_i = 32'hB000_0000 + 32'(b);
      @(posedge clk); #1;
    end
    a_if.s_ack_i = 1'b0; a_if.s_dat_i = '0;
    a_set(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    chk("burst_hold_tail", 64'(a_if.gnt_o), 64'b0001);
    @(negedge clk);
    chk("burst_dead", 64'(a_if.gnt_o), 64'b0000);
    @(negedge clk);
    chk("burst_next_gnt", 64'(a_if.gnt_o), 64'b0010);
    chk("burst_next_adr", 64'(a_if.s_adr_o), 64'h200);
    @(posedge clk); #1;
    push(4'b0010, 32'h0000_0200, 32'h0000_0055, 1'b1, 3'b000, 32'h0);
    a_if.s_ack_i = 1'b1;
    @(posedge clk); #1;
    a_if.s_ack_i = 1'b0;
    a_set(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (2) @(posedge clk); #1;

    // A: watchdog, slave never acks
    a_set(2, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b000);
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) chk("wd_gnt", 64'(a_if.gnt_o), 64'b0100);
      if (c < 9)
        chk("wd_wait", 64'({a_if.m_err_o, a_if.timeout_o, a_if.s_cyc_o, a_if.s_stb_o}),
            64'b0000_0_1_1);
      else
        chk("wd_fire", 64'({a_if.m_err_o, a_if.timeout_o, a_if.s_cyc_o, a_if.s_stb_o}),
            64'b0100_1_0_0);
    end
    @(posedge clk); #1;
    a_if.s_ack_i = 1'b1;
    @(negedge clk);
    chk("wd_drain", 64'({a_if.m_ack_o, a_if.m_err_o, a_if.timeout_o, a_if.s_cyc_o, a_if.gnt_o}),
        64'b0000_0000_0_0_0100);
    @(posedge clk); #1;
    a_if.s_ack_i = 1'b0;
    a_set(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk); @(negedge clk);
    chk("wd_idle", 64'(a_if.gnt_o), 64'b0000);
    @(posedge clk); #1;

    // A: asynchronous reset in the middle of a burst
    a_set(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'b010);
    a_set(1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'b000);
    @(posedge clk); #1;
    push(4'b0001, 32'h0000_0400, 32'h0, 1'b0, 3'b010, 32'hC000_0000);
    a_if.s_ack_i = 1'b1; a_if.s_dat_i = 32'hC000_0000;
    @(posedge clk); #1;
    a_set(0, 1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 3'b010);
    push(4'b0001, 32'h0000_0404, 32'h0, 1'b0, 3'b010, 32'hC000_0001);
    a_if.s_dat_i = 32'hC000_0001;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", 64'({a_if.gnt_o, a_if.s_cyc_o, a_if.s_stb_o, a_if.s_adr_o,
                        a_if.m_ack_o, a_if.m_err_o, a_if.timeout_o}), 64'd0);
    a_if.s_ack_i = 1'b0; a_if.s_dat_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_idle", 64'(a_if.gnt_o), 64'b0000);
    @(negedge clk);
    chk("rst_first_gnt", 64'(a_if.gnt_o), 64'b0001);
    chk("rst_first_adr", 64'(a_if.s_adr_o), 64'h404);
    @(posedge clk); #1;
    a_set(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    a_set(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (3) @(posedge clk);

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout got stuck want finish");
    $fatal(1, "bench timeout");
  end
endmodule
